// File: rtl/fm_audio_pacer.sv
`default_nettype none
// ============================================================================
// Module   : fm_audio_pacer
// Purpose  : Paces 16-bit signed audio samples into the FM sine generator.
//            Samples arrive over a valid/ready handshake into a small FIFO.
//            One sample is released per audio-rate tick as an offset-binary
//            modulation word. The block also drives the generator's phase-step
//            pulse train. Priming, underrun (carrier-centre parking) and flush
//            are handled here.
// Ports    : clk_in, rst_in (async, active high), enable_in, flush_in,
//            in_data/in_valid/in_ready (sample input handshake),
//            audio_mod_out (offset binary, 16'h8000 = carrier centre),
//            step_out, running_out, underrun_count, fifo_level
// Options  : FM_PACER_SOFT_MUTE_EN - slew audio_mod_out toward centre by
//            RAMP_STEP per tick after leaving RUN instead of snapping to it.
// Revision : 1.0 - initial release
// ============================================================================
module fm_audio_pacer #(
  parameter int          CLK_FREQ    = 250_000_000,
  parameter int          SAMPLE_RATE = 48_000,
  parameter int          STEP_DIV    = 1,
  parameter int          FIFO_DEPTH  = 16,
  parameter int          PRIME_LEVEL = 8,
  parameter logic [15:0] RAMP_STEP   = 16'd512
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            enable_in,
  input  logic                            flush_in,
  input  logic [15:0]                     in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [15:0]                     audio_mod_out,
  output logic                            step_out,
  output logic                            running_out,
  output logic [15:0]                     underrun_count,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_LW = c_AW + 1;
  localparam int c_DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [31:0]      c_SR        = 32'(SAMPLE_RATE);
  localparam logic [31:0]      c_CF        = 32'(CLK_FREQ);
  localparam logic [c_LW-1:0]  c_PRIME     = c_LW'(PRIME_LEVEL);
  localparam logic [c_LW-1:0]  c_FULL      = c_LW'(FIFO_DEPTH);
  localparam logic [c_DW-1:0]  c_DIV_LAST  = c_DW'(STEP_DIV - 1);
  localparam logic [15:0]      c_CENTRE    = 16'h8000;

`ifdef FM_PACER_SOFT_MUTE_EN
  localparam logic [15:0]      c_RAMP      = RAMP_STEP;
`else
  // Full-scale step: any word reaches centre in a single update, so the
  // shared slew path degenerates into "force centre on the next edge".
  localparam logic [15:0]      c_RAMP      = RAMP_STEP | 16'hFFFF;
`endif

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_PRIME    = 2'd1;
  localparam logic [1:0] S_RUN      = 2'd2;
  localparam logic [1:0] S_UNDERRUN = 2'd3;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]       state_q, state_d;
  logic [15:0]      mod_q, mod_d;
  logic [15:0]      urun_q, urun_d;
  logic [31:0]      acc_q;
  logic [c_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [c_LW-1:0]  level_q;
  logic [c_DW-1:0]  div_q;
  logic             step_q;
  logic [15:0]      mem_q [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic [31:0]      w_acc_sum;
  logic             w_tick;
  logic             w_full, w_empty;
  logic             w_in_ready, w_push, w_pop;
  logic [15:0]      w_rd_data;
  logic             w_slew_evt;

  function automatic logic [15:0] f_slew(input logic [15:0] v, input logic [15:0] s);
    logic [15:0] r;
    if (v > c_CENTRE) begin
      r = ((v - c_CENTRE) > s) ? (v - s) : c_CENTRE;
    end else if (v < c_CENTRE) begin
      r = ((c_CENTRE - v) > s) ? (v + s) : c_CENTRE;
    end else begin
      r = v;
    end
    return r;
  endfunction

  assign w_acc_sum  = acc_q + c_SR;
  assign w_tick     = enable_in && (w_acc_sum >= c_CF);
  assign w_full     = (level_q == c_FULL);
  assign w_empty    = (level_q == '0);
  assign w_in_ready = !w_full && !flush_in;
  assign w_push     = in_valid && w_in_ready;
  // Flush wins over pop: a tick coinciding with flush releases nothing.
  assign w_pop      = (state_q == S_RUN) && w_tick && !w_empty && !flush_in;
  assign w_rd_data  = mem_q[rd_ptr_q];

`ifdef FM_PACER_SOFT_MUTE_EN
  // Free-running tick keeps the slew moving while IDLE (enable_in low holds
  // the main accumulator at zero).
  logic [31:0] free_acc_q;
  logic [31:0] w_free_sum;
  logic        w_free_tick;

  assign w_free_sum  = free_acc_q + c_SR;
  assign w_free_tick = (w_free_sum >= c_CF);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      free_acc_q <= '0;
    end else begin
      free_acc_q <= w_free_tick ? (w_free_sum - c_CF) : w_free_sum;
    end
  end

  assign w_slew_evt = (state_q == S_IDLE) ? w_free_tick : w_tick;
`else
  assign w_slew_evt = 1'b1;
`endif

  // --------------------------------------------------------------------------
  // Sample-rate phase accumulator
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      acc_q <= '0;
    end else if (!enable_in) begin
      acc_q <= '0;
    end else begin
      acc_q <= w_tick ? (w_acc_sum - c_CF) : w_acc_sum;
    end
  end

  // --------------------------------------------------------------------------
  // Step pulse divider
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      div_q  <= '0;
      step_q <= 1'b0;
    end else if (!enable_in) begin
      div_q  <= '0;
      step_q <= 1'b0;
    end else begin
      step_q <= (div_q == '0);
      div_q  <= (div_q == c_DIV_LAST) ? '0 : div_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Sample FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM and modulation output
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mod_d   = mod_q;
    urun_d  = urun_q;
    if (!enable_in) begin
      state_d = S_IDLE;
      if (w_slew_evt) mod_d = f_slew(mod_q, c_RAMP);
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_PRIME;
          if (w_slew_evt) mod_d = f_slew(mod_q, c_RAMP);
        end
        S_PRIME, S_UNDERRUN: begin
          if (level_q >= c_PRIME) state_d = S_RUN;
          if (w_slew_evt) mod_d = f_slew(mod_q, c_RAMP);
        end
        S_RUN: begin
          if (w_pop) begin
            mod_d = {~w_rd_data[15], w_rd_data[14:0]};
          end else if (w_tick && w_empty) begin
            state_d = S_UNDERRUN;
            if (urun_q != 16'hFFFF) urun_d = urun_q + 16'd1;
            mod_d = f_slew(mod_q, c_RAMP);
          end
        end
        default: begin
          state_d = S_IDLE;
          mod_d   = c_CENTRE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      mod_q   <= c_CENTRE;
      urun_q  <= '0;
    end else begin
      state_q <= state_d;
      mod_q   <= mod_d;
      urun_q  <= urun_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready       = w_in_ready;
  assign audio_mod_out  = mod_q;
  assign step_out       = step_q;
  assign running_out    = (state_q == S_RUN);
  assign underrun_count = urun_q;
  assign fifo_level     = level_q;

endmodule
`default_nettype wire
